// File: rtl/axis_frame_tx.sv
// Generates counting-pattern AXI-Stream frames from length/dest/user descriptors.
// Latency: first beat valid 1 cycle after descriptor accept, then 1 beat/cycle.
// Backpressure: outputs hold while tvalid && !tready; descriptors wait while a frame is in flight.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic [DEST_WIDTH-1:0] s_desc_dest,
  input  logic [USER_WIDTH-1:0] s_desc_user,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  status_busy,
  output logic                  status_frame_done,
  output logic                  status_len_error
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int PW = LEN_WIDTH + 2;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0] len_q;
  logic [CW-1:0]        beat_total_q;
  logic [CW-1:0]        beat_idx_q;
  logic [CW-1:0]        off_q;
  logic [7:0]           frame_cnt;

  logic                  desc_acc, desc_start, beat_acc, last_acc, load;
  logic [CW-1:0]         desc_total;
  logic [LEN_WIDTH-1:0]  beat_len;
  logic [CW-1:0]         beat_off;
  logic [PW-1:0]         lane_pos;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] beat_keep;
  logic                  beat_last;

  assign s_desc_ready = (state == IDLE) && !rst;
  assign status_busy  = (state == SEND);
  assign desc_acc     = s_desc_valid && s_desc_ready;
  assign desc_start   = desc_acc && (s_desc_len != '0);
  assign beat_acc     = m_axis_tvalid && m_axis_tready;
  assign last_acc     = beat_acc && m_axis_tlast;
  assign load         = desc_start || (beat_acc && !m_axis_tlast);
  assign desc_total   = (CW'(s_desc_len) + CW'(KEEP_WIDTH - 1)) / CW'(KEEP_WIDTH);

  // Next beat to present: beat 0 of the incoming descriptor, or the successor of the current beat.
  always_comb begin
    beat_len  = (state == IDLE) ? s_desc_len : len_q;
    beat_off  = (state == IDLE) ? '0 : off_q + CW'(KEEP_WIDTH);
    beat_last = (state == IDLE) ? (desc_total == CW'(1))
                                : (beat_idx_q + CW'(2) == beat_total_q);
    beat_data = '0;
    beat_keep = '0;
    lane_pos  = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      lane_pos = {1'b0, beat_off} + PW'(k);
      if (lane_pos < {2'b00, beat_len}) begin
        beat_keep[k]        = 1'b1;
        beat_data[8*k +: 8] = frame_cnt + lane_pos[7:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (desc_start) state_nxt = SEND;
      SEND:    if (last_acc)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      status_frame_done <= 1'b0;
      status_len_error  <= 1'b0;
      frame_cnt         <= 8'd0;
    end else begin
      status_frame_done <= last_acc;
      status_len_error  <= desc_acc && (s_desc_len == '0);
      if (desc_start) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= beat_last;
      end else if (last_acc) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        frame_cnt     <= frame_cnt + 8'd1;
      end else if (beat_acc) begin
        m_axis_tlast  <= beat_last;
      end
    end
  end

  // Payload registers are not reset; every load rewrites unused lanes with zero.
  always_ff @(posedge clk) begin
    if (load) begin
      m_axis_tdata <= beat_data;
      m_axis_tkeep <= beat_keep;
      off_q        <= beat_off;
    end
    if (desc_start) begin
      len_q        <= s_desc_len;
      m_axis_tdest <= s_desc_dest;
      m_axis_tuser <= s_desc_user;
      beat_total_q <= desc_total;
      beat_idx_q   <= '0;
    end else if (beat_acc && !m_axis_tlast) begin
      beat_idx_q   <= beat_idx_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Randomized bench for axis_frame_tx (32-bit data) against a frame-level reference model.
module tb_axis_frame_tx;
  localparam int DW = 32, KW = 4, LW = 16, DESTW = 8, UW = 1;
  localparam int NCYC = 4000, DRAIN = 300;

  logic clk;
  logic rst;
  logic [LW-1:0]    s_desc_len;
  logic [DESTW-1:0] s_desc_dest;
  logic [UW-1:0]    s_desc_user;
  logic             s_desc_valid, s_desc_ready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DESTW-1:0] m_axis_tdest;
  logic [UW-1:0]    m_axis_tuser;
  logic             status_busy, status_frame_done, status_len_error;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_frame_tx #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW),
                  .DEST_WIDTH(DESTW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_desc_len(s_desc_len), .s_desc_dest(s_desc_dest), .s_desc_user(s_desc_user),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .status_busy(status_busy), .status_frame_done(status_frame_done),
    .status_len_error(status_len_error)
  );

  typedef struct {
    logic [DW-1:0]    data;
    logic [KW-1:0]    keep;
    logic             last;
    logic [DESTW-1:0] dest;
    logic [UW-1:0]    user;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int fcnt_m = 0, n_desc = 0, n_frames = 0;
  logic busy_m = 1'b0;

  // Values seen just before the upcoming rising edge.
  logic             e_rst = 1'b1, e_tvalid, e_tready, e_dvalid, e_dready, e_last;
  logic [LW-1:0]    e_len;
  logic [DESTW-1:0] e_dest, e_tdest;
  logic [UW-1:0]    e_user, e_tuser;
  logic [DW-1:0]    e_data;
  logic [KW-1:0]    e_keep;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame of len bytes: byte i of the frame is (fc + i) mod 256, packed KW per beat.
  task automatic push_frame(input int len, input logic [DESTW-1:0] dest,
                            input logic [UW-1:0] user, input int fc);
    int nb;
    int pos;
    beat_t bt;
    nb = (len + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int k = 0; k < KW; k++) begin
        pos = b * KW + k;
        if (pos < len) begin
          bt.keep[k]        = 1'b1;
          bt.data[8*k +: 8] = 8'((fc + pos) % 256);
        end
      end
      bt.last = (b == nb - 1);
      bt.dest = dest;
      bt.user = user;
      exp_q.push_back(bt);
    end
  endtask

  initial begin
    beat_t bt;
    logic exp_fd, exp_le, did_mid_rst;
    int tr_mode;
    rst = 1'b1;
    m_axis_tready = 1'b0;
    s_desc_valid = 1'b0;
    s_desc_len = '0;
    s_desc_dest = '0;
    s_desc_user = '0;
    did_mid_rst = 1'b0;
    tr_mode = 0;
    for (int cyc = 0; cyc < NCYC + DRAIN; cyc++) begin
      @(negedge clk);
      exp_fd = 1'b0;
      exp_le = 1'b0;
      if (e_rst) begin
        busy_m = 1'b0;
        exp_q.delete();
        fcnt_m = 0;
      end else begin
        if (e_tvalid && e_tready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", 1, 0);
          end else begin
            bt = exp_q.pop_front();
            chk("tdata", e_data, bt.data);
            chk("tkeep", e_keep, bt.keep);
            chk("tlast", e_last, bt.last);
            chk("tdest", e_tdest, bt.dest);
            chk("tuser", e_tuser, bt.user);
            if (bt.last) begin
              busy_m = 1'b0;
              fcnt_m = (fcnt_m + 1) % 256;
              exp_fd = 1'b1;
              n_frames++;
            end
          end
        end
        if (e_dvalid && e_dready) begin
          s_desc_valid = 1'b0;
          if (e_len == '0) begin
            exp_le = 1'b1;
          end else begin
            push_frame(int'(e_len), e_dest, e_user, fcnt_m);
            busy_m = 1'b1;
          end
        end
        if (e_tvalid && !e_tready)
          chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdest,
                             m_axis_tuser, m_axis_tdata},
                            {1'b1, e_last, e_keep, e_tdest, e_tuser, e_data});
      end
      chk("tvalid", m_axis_tvalid, busy_m);
      chk("busy", status_busy, busy_m);
      chk("desc_ready", s_desc_ready, !busy_m && !rst);
      chk("frame_done", status_frame_done, exp_fd);
      chk("len_error", status_len_error, exp_le);
      if (!busy_m) chk("tlast_idle", m_axis_tlast, 0);

      // Drive inputs for the next edge.
      rst = (cyc < 3);
      if (cyc >= 60 && cyc < NCYC) begin
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        if (!did_mid_rst && cyc > 1000 && busy_m && exp_q.size() >= 2) begin
          rst = 1'b1;
          did_mid_rst = 1'b1;
        end
      end
      if (cyc % 64 == 0) tr_mode = $urandom_range(0, 2);
      if (cyc < 60 || cyc >= NCYC || tr_mode == 0) m_axis_tready = 1'b1;
      else if (tr_mode == 1) m_axis_tready = ($urandom_range(0, 1) == 1);
      else m_axis_tready = ($urandom_range(0, 4) != 0);
      if (!s_desc_valid && cyc >= 3 && cyc < NCYC && (n_desc < 2 || $urandom_range(0, 2) == 0)) begin
        s_desc_valid = 1'b1;
        s_desc_user = UW'($urandom_range(0, 1));
        if (n_desc == 0) begin
          s_desc_len = LW'(3);
          s_desc_dest = 8'd5;
        end else if (n_desc == 1) begin
          s_desc_len = LW'(6);
          s_desc_dest = 8'd9;
        end else begin
          s_desc_dest = DESTW'($urandom_range(0, 255));
          case ($urandom_range(0, 9))
            0:       s_desc_len = '0;
            1, 2:    s_desc_len = LW'($urandom_range(1, KW));
            default: s_desc_len = LW'($urandom_range(1, 40));
          endcase
        end
        n_desc++;
      end
      #1;
      e_rst = rst;       e_tvalid = m_axis_tvalid; e_tready = m_axis_tready;
      e_dvalid = s_desc_valid; e_dready = s_desc_ready;
      e_len = s_desc_len; e_dest = s_desc_dest;  e_user = s_desc_user;
      e_data = m_axis_tdata; e_keep = m_axis_tkeep; e_last = m_axis_tlast;
      e_tdest = m_axis_tdest; e_tuser = m_axis_tuser;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", status_busy, 0);
    chk("frames_seen", n_frames > 20, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
